// File: rtl/fpu_pipe_ctrl.sv
// fpu_pipe_ctrl: occupancy/advance controller for a multi-stage FPU datapath.
// Tracks one valid bit and one tag per stage, stalls the whole pipe when
// the last stage holds a result the consumer will not take, and supports a
// synchronous flush that discards every in-flight operation.
//
// Handshakes (valid/ready):
//   upstream   - an operation transfers on a cycle where start & in_ready;
//                start with in_ready low is simply not taken (no queuing).
//   downstream - the last-stage result transfers on a cycle where
//                stage_vld[STAGES-1] & out_ready (and no flush); done marks
//                that transfer. Neither side may depend on the other's
//                same-cycle response to decide whether to assert its own.
module fpu_pipe_ctrl #(
  parameter int STAGES = 5,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              in_ready,
  input  logic              flush,
  input  logic              out_ready,
  output logic [STAGES-1:0] stage_vld,
  output logic [STAGES-1:0] stage_en,
  output logic              done,
  output logic [TAG_W-1:0]  tag_out,
  output logic              busy,
  output logic [CNT_W-1:0]  count
);

  // Per-stage valid bits and tags; tags are only meaningful where v is set.
  logic [STAGES-1:0] v;
  logic [TAG_W-1:0]  t [STAGES];

  logic              stall;
  logic              adv;
  logic              accept;
  logic [CNT_W-1:0]  count_c;

  // Global stall: the last stage is full and the consumer is not taking it.
  // Every stage holds together, so bubbles ahead of the stall also hold.
  assign stall  = v[STAGES-1] & ~out_ready;
  assign adv    = ~stall & ~flush;
  assign accept = start & adv;

  assign in_ready  = adv;
  assign stage_vld = v;
  assign stage_en  = v & {STAGES{adv}};
  assign done      = v[STAGES-1] & out_ready & ~flush;
  assign tag_out   = t[STAGES-1];
  assign busy      = |v;
  assign count     = count_c;

  // Occupancy is the population count of the valid bits.
  always_comb begin
    count_c = '0;
    for (int i = 0; i < STAGES; i++) begin
      count_c = count_c + CNT_W'(v[i]);
    end
  end

  // Valid-bit shift register: reset and flush empty it, stall holds it.
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
    end else if (flush) begin
      v <= '0;
    end else if (adv) begin
      v <= {v[STAGES-2:0], accept};
    end
  end

  // Tag shift register: no reset, it moves in lockstep with the valid bits.
  always_ff @(posedge clk) begin
    if (adv) begin
      if (accept) begin
        t[0] <= tag_in;
      end
      for (int i = 1; i < STAGES; i++) begin
        t[i] <= t[i-1];
      end
    end
  end

endmodule

// File: tb/tb_fpu_pipe_ctrl.sv
// Testbench for fpu_pipe_ctrl: directed timing checks on a 5-stage/4-bit
// instance plus scoreboarded random traffic on a 2-stage/8-bit instance.
module tb_fpu_pipe_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT A: STAGES=5, TAG_W=4 ----------------
  logic       start5 = 1'b0;
  logic [3:0] tag_in5 = '0;
  logic       flush5 = 1'b0;
  logic       ready5 = 1'b1;
  logic       in_ready5;
  logic [4:0] vld5;
  logic [4:0] en5;
  logic       done5;
  logic [3:0] tag_out5;
  logic       busy5;
  logic [2:0] count5;

  fpu_pipe_ctrl #(.STAGES(5), .TAG_W(4)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .tag_in(tag_in5),
    .in_ready(in_ready5), .flush(flush5), .out_ready(ready5),
    .stage_vld(vld5), .stage_en(en5), .done(done5), .tag_out(tag_out5),
    .busy(busy5), .count(count5)
  );

  // ---------------- DUT B: STAGES=2, TAG_W=8 ----------------
  logic       start2 = 1'b0;
  logic [7:0] tag_in2 = '0;
  logic       flush2 = 1'b0;
  logic       ready2 = 1'b1;
  logic       in_ready2;
  logic [1:0] vld2;
  logic [1:0] en2;
  logic       done2;
  logic [7:0] tag_out2;
  logic       busy2;
  logic [1:0] count2;

  fpu_pipe_ctrl #(.STAGES(2), .TAG_W(8)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .tag_in(tag_in2),
    .in_ready(in_ready2), .flush(flush2), .out_ready(ready2),
    .stage_vld(vld2), .stage_en(en2), .done(done2), .tag_out(tag_out2),
    .busy(busy2), .count(count2)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboards ----------------
  logic [3:0] exp5_q[$];
  logic [7:0] exp2_q[$];
  int acc2 = 0;
  int done2_n = 0;

  // DUT A: tags in issue order, popped when a result leaves.
  always @(negedge clk) begin
    if (rst) begin
      exp5_q.delete();
    end else begin
      if (done5) begin
        if (exp5_q.size() == 0) check("sb5_unexpected_done", 32'd1, 32'd0);
        else check("sb5_tag", 32'(tag_out5), 32'(exp5_q.pop_front()));
      end
      if (flush5) exp5_q.delete();
      else if (start5 && in_ready5) exp5_q.push_back(tag_in5);
    end
  end

  // DUT B: same ordering scoreboard plus accept/done counters.
  always @(negedge clk) begin
    if (rst) begin
      exp2_q.delete();
    end else begin
      if (done2) begin
        done2_n++;
        if (exp2_q.size() == 0) check("sb2_unexpected_done", 32'd1, 32'd0);
        else check("sb2_tag", 32'(tag_out2), 32'(exp2_q.pop_front()));
      end
      if (flush2) exp2_q.delete();
      else if (start2 && in_ready2) begin
        exp2_q.push_back(tag_in2);
        acc2++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_no_done(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      check(name, 32'(done5), 32'd0);
      cyc();
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int exp_cnt;

    // Reset
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    sample();
    check("rst_vld", 32'(vld5), 32'd0);
    check("rst_en", 32'(en5), 32'd0);
    check("rst_done", 32'(done5), 32'd0);
    check("rst_busy", 32'(busy5), 32'd0);
    check("rst_count", 32'(count5), 32'd0);
    check("rst_in_ready", 32'(in_ready5), 32'd1);
    check("rst_in_ready2", 32'(in_ready2), 32'd1);
    cyc();

    // Single operation walks the pipe
    start5 = 1'b1; tag_in5 = 4'h3; ready5 = 1'b1;
    sample();
    check("single_in_ready", 32'(in_ready5), 32'd1);
    cyc();
    start5 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      sample();
      check("single_vld", 32'(vld5), 32'(1 << (k - 1)));
      check("single_count", 32'(count5), 32'd1);
      check("single_done", 32'(done5), (k == 5) ? 32'd1 : 32'd0);
      if (k == 5) check("single_tag", 32'(tag_out5), 32'h3);
      cyc();
    end
    sample();
    check("single_count_end", 32'(count5), 32'd0);
    check("single_busy_end", 32'(busy5), 32'd0);
    cyc();

    // Five back-to-back operations
    for (int m = 0; m <= 10; m++) begin
      start5 = (m < 5);
      tag_in5 = 4'(m + 1);
      sample();
      exp_cnt = 0;
      for (int k = 0; k < 5; k++) if (m >= k + 1 && m <= k + 5) exp_cnt++;
      check("b2b_count", 32'(count5), 32'(exp_cnt));
      check("b2b_done", 32'(done5), (m >= 5 && m <= 9) ? 32'd1 : 32'd0);
      if (m >= 5 && m <= 9) check("b2b_tag", 32'(tag_out5), 32'(m - 4));
      cyc();
    end
    start5 = 1'b0;

    // Fill, stall three cycles with a start offered, then drain
    for (int m = 0; m < 5; m++) begin
      start5 = 1'b1; tag_in5 = 4'(6 + m);
      cyc();
    end
    ready5 = 1'b0;
    for (int s = 0; s < 3; s++) begin
      start5 = (s == 1); tag_in5 = 4'hF;
      sample();
      check("stall_vld", 32'(vld5), 32'h1F);
      check("stall_in_ready", 32'(in_ready5), 32'd0);
      check("stall_en", 32'(en5), 32'd0);
      check("stall_done", 32'(done5), 32'd0);
      check("stall_count", 32'(count5), 32'd5);
      cyc();
    end
    start5 = 1'b0; ready5 = 1'b1;
    for (int j = 0; j < 5; j++) begin
      sample();
      if (j == 0) check("release_en", 32'(en5), 32'h1F);
      check("drain_done", 32'(done5), 32'd1);
      check("drain_tag", 32'(tag_out5), 32'(6 + j));
      cyc();
    end
    sample();
    check("drain_busy", 32'(busy5), 32'd0);
    cyc();

    // Flush with three in flight and a concurrent start
    for (int m = 0; m < 3; m++) begin
      start5 = 1'b1; tag_in5 = 4'(1 + m);
      cyc();
    end
    start5 = 1'b1; tag_in5 = 4'h4; flush5 = 1'b1;
    sample();
    check("flush_vld_before", 32'(vld5), 32'h07);
    check("flush_done", 32'(done5), 32'd0);
    check("flush_in_ready", 32'(in_ready5), 32'd0);
    check("flush_en", 32'(en5), 32'd0);
    cyc();
    start5 = 1'b0; flush5 = 1'b0;
    sample();
    check("flush_vld_after", 32'(vld5), 32'd0);
    check("flush_count_after", 32'(count5), 32'd0);
    check("flush_in_ready_after", 32'(in_ready5), 32'd1);
    cyc();
    idle_no_done("flush_no_done", 6);

    // Reset two cycles after a start
    start5 = 1'b1; tag_in5 = 4'h5;
    cyc();
    start5 = 1'b0;
    cyc();
    rst = 1'b1;
    sample();
    check("midrst_vld_before", 32'(vld5), 32'h02);
    cyc();
    rst = 1'b0;
    sample();
    check("midrst_vld", 32'(vld5), 32'd0);
    check("midrst_busy", 32'(busy5), 32'd0);
    check("midrst_count", 32'(count5), 32'd0);
    check("midrst_in_ready", 32'(in_ready5), 32'd1);
    cyc();
    idle_no_done("midrst_no_done", 6);

    // STAGES=2 random traffic with alternating out_ready
    for (int c = 0; c < 40; c++) begin
      start2 = 1'($urandom_range(0, 1));
      tag_in2 = 8'($urandom_range(0, 255));
      ready2 = c[0];
      cyc();
    end
    start2 = 1'b0; ready2 = 1'b1;
    for (int c = 0; c < 4; c++) cyc();
    sample();
    check("s2_done_eq_accept", 32'(done2_n), 32'(acc2));
    check("s2_queue_empty", 32'(exp2_q.size()), 32'd0);
    check("s2_busy_end", 32'(busy2), 32'd0);
    check("s2_some_traffic", 32'(acc2 > 0), 32'd1);
    check("s5_queue_empty", 32'(exp5_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
